water_dispense_arbiter: RTL



---
 rtl/water_dispense_pkg.sv | 15 +
 rtl/water_dispense_arbiter_rr_picker.sv | 34 +++
 rtl/water_dispense_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/water_dispense_pkg.sv
// Shared types and defaults for the water dispense arbiter.
// State encoding, timer width and default timing constants.
package water_dispense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    COOL
  } state_e;

  localparam int TIMER_W      = 4;
  localparam int MAX_TIME_DEF = 10;
  localparam int COOLDOWN_DEF = 2;

endpackage

// File: rtl/water_dispense_arbiter_rr_picker.sv
// Combinational round-robin select over the pending vector.
// Returns the first set bit at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  // Scan stations starting at the pointer; the first hit wins.
  always_comb begin
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr_i) + k) % N_REQ;
      if (!found && pending_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

  assign valid_o = |pending_i;

endmodule

// File: rtl/water_dispense_arbiter.sv
// Round-robin valve arbiter with per-grant limit and cool-down.
// Optional stats outputs under WATER_DISPENSE_STATS_EN.
module water_dispense_arbiter
  import water_dispense_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_TIME = MAX_TIME_DEF,
  parameter int COOLDOWN = COOLDOWN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   start_dispense,
  input  logic [N_REQ-1:0]   stop_dispense,
  output logic [N_REQ-1:0]   grant,
  output logic               water_flow,
  output logic               dispense_active,
  output logic [TIMER_W-1:0] timer,
`ifdef WATER_DISPENSE_STATS_EN
  output logic [N_REQ*8-1:0] usage_count,
  output logic               any_timeout_seen,
`endif
  output logic               timeout
);

  localparam int PW = $clog2(N_REQ);

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     pending_q, pending_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   cool_q, cool_d;
  logic                 timeout_q, timeout_d;

  logic [N_REQ-1:0]     pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_valid;
  logic                 stop_own;
  logic                 at_limit;
  logic [N_REQ-1:0]     start_m;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  assign stop_own = |(stop_dispense & grant_q);
  assign at_limit = (timer_q == TIMER_W'(MAX_TIME - 1));

  // Next-state, pending latch and grant bookkeeping.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    cool_d    = cool_q;
    timeout_d = 1'b0;
    start_m   = start_dispense;
    if (state_q == DISPENSE) start_m = start_dispense & ~grant_q;
    pending_d = (pending_q | start_m) & ~stop_dispense;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = DISPENSE;
          grant_d   = pick_gnt;
          owner_d   = pick_idx;
          timer_d   = '0;
          pending_d = pending_d & ~pick_gnt;
        end
      end
      DISPENSE: begin
        timer_d = timer_q + TIMER_W'(1);
        if (stop_own || at_limit) begin
          state_d   = COOL;
          grant_d   = '0;
          timer_d   = '0;
          cool_d    = '0;
          timeout_d = at_limit && !stop_own;
          rr_ptr_d  = (owner_q == PW'(N_REQ - 1)) ? '0
                                                   : owner_q + PW'(1);
        end
      end
      COOL: begin
        if (cool_q == TIMER_W'(COOLDOWN - 1)) state_d = IDLE;
        else cool_d = cool_q + TIMER_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      cool_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      cool_q    <= cool_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant           = grant_q;
  assign water_flow      = (state_q == DISPENSE);
  assign dispense_active = (state_q != IDLE);
  assign timer           = timer_q;
  assign timeout         = timeout_q;

`ifdef WATER_DISPENSE_STATS_EN
  logic [N_REQ*8-1:0] usage_q;
  logic               seen_q;

  // Saturating per-station grant counters and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      usage_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      if (timeout_d) seen_q <= 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (state_q == IDLE && pick_gnt[i] &&
            usage_q[i*8 +: 8] != 8'hFF)
          usage_q[i*8 +: 8] <= usage_q[i*8 +: 8] + 8'd1;
      end
    end
  end

  assign usage_count      = usage_q;
  assign any_timeout_seen = seen_q;
`endif

endmodule
